iambic_element_sequencer: RTL and testbench
===========================================

Name: iambic_element_sequencer

Overview:
- Paddle-to-key scheduler for the Morse keyer datapath.
- Sequences dit/dah elements and inter-element spaces from the paddle inputs, using an internal unit timer programmed in clock cycles per dit.
- Supports iambic A/B and straight-key modes.
- Drives the key/aux outputs that feed the buzzer, and emits gap events (char/word end) to the decoder and 7-seg logic.

Parameters:
UNIT_W, 20, width of unit-length count (cycles per dit unit; 600000 cycles = 20 WPM at 10 MHz)

Ports:
clk_i  input  1  system clock
rstn_i  input  1  reset; asynchronous, active-low
unit_len_i  input  UNIT_W  cycles per Morse unit; value 0 treated as 1
paddle_sel_i  input  1  1 = iambic paddle, 0 = straight key on dit_i
iambic_AB_i  input  1  0 = mode A, 1 = mode B
dit_i  input  1  dit paddle / straight key, active-high, already synchronized
dah_i  input  1  dah paddle, active-high, already synchronized
key_o  output  1  keyed Morse output, active-high
aux_dit_o  output  1  high while a dit element is ON
aux_dah_o  output  1  high while a dah element is ON
elem_done_o  output  1  1-cycle pulse at end of each element's ON time
elem_is_dah_o  output  1  valid with elem_done_o: 1 = dah, 0 = dit
char_end_o  output  1  1-cycle pulse when the key-up gap reaches 3 units
word_end_o  output  1  1-cycle pulse when the key-up gap reaches 7 units
busy_o  output  1  high in any state except IDLE

Behaviour:
- Reset (async, rstn_i low): state IDLE; all outputs 0; unit counter, gap counter, last-element flag and squeeze flag cleared. Reset mid-element drops key_o immediately.
- Unit timer: down-counter loaded with max(unit_len_i,1)-1 at element/space/gap start. Unit boundary = count 0, then reload. unit_len_i is sampled only at load, so a change takes effect at the next boundary.
- Paddle states: IDLE, DIT_ON (1 unit), DAH_ON (3 units), SPACE (1 unit, key low), GAP.
- All outputs are registered. A press sampled at edge k shows key_o=1 from edge k+1. ON time is exactly N*unit_len cycles.
- IDLE or GAP, paddle mode:
  - dit_i → DIT_ON.
  - else dah_i → DAH_ON.
  - Both pressed → dit first.
- ON end → elem_done_o/elem_is_dah_o pulse on the same cycle key_o falls; record last element; go to SPACE.
- Squeeze flag: set whenever dit_i & dah_i during ON or SPACE; cleared at each element start.
- Decision at SPACE end, mode A:
  - both pressed → opposite of last.
  - only dit → DIT_ON.
  - only dah → DAH_ON.
  - none → GAP.
- Decision at SPACE end, mode B: as mode A, except with squeeze flag set:
  - none pressed → opposite of last.
  - only the same paddle as last pressed → opposite of last.
- GAP:
  - Gap counter starts at 1, since SPACE already counted one unit; +1 per unit boundary.
  - Reaching 3 → char_end_o pulse.
  - Reaching 7 → word_end_o pulse, then IDLE.
  - A press during GAP restarts an element immediately. No char_end is emitted if the gap count was below 3.
  - Gap counter saturates; no repeated pulses.
- Straight mode (paddle_sel_i=0):
  - key_o = registered dit_i; dah_i ignored; aux_dit_o/aux_dah_o held 0.
  - On release: elem_done_o pulses with elem_is_dah_o=0; enter GAP with counter 0, timer loaded at release. char_end_o at 3 units, word_end_o at 7 units after key_o falls.
- Mode changes (paddle_sel_i, iambic_AB_i) are sampled only in IDLE/GAP.
- Simultaneous events: a press on the same cycle as the GAP count reaching 3 → the element starts and char_end_o still pulses.

Test Plan:
- Mode A, unit_len=4, dit pulse held 2 cycles → key_o high 4 cycles, low; elem_done_o=1, elem_is_dah_o=0; char_end_o 12 cycles after key_o falls; word_end_o 28 cycles after; busy_o=0 after.
- Dah held 20 cycles, unit_len=4 → key 12 on / 4 off, then one more 12-cycle dah (still held at SPACE end), then GAP.
- Squeeze both from IDLE, release during first dit ON, mode A → single dit only. Same stimulus in mode B → dit then dah (dah 12 cycles).
- Both held continuously, mode A → alternating dit, dah, dit, dah with 4-cycle spaces; elem_is_dah_o toggles each elem_done_o.
- Straight mode, dit_i high 10 cycles, unit_len=3 → key_o high 10 cycles delayed 1; char_end_o 9 cycles and word_end_o 21 cycles after key_o falls; dah_i toggling has no effect.
- Reset asserted mid-DAH_ON → key_o/aux_dah_o 0 asynchronously; after release with no paddles pressed, state stays IDLE and no gap pulses occur. unit_len_i=0 → 1-cycle dits.

Source files
------------

// File: rtl/iambic_element_sequencer_if.sv
// Paddle, configuration and keying signals of the iambic element sequencer.
// master = paddle/config source and output sink, slave = sequencer.
interface iambic_element_sequencer_if #(
    parameter int unsigned UNIT_W = 20
);
    logic [UNIT_W-1:0] unit_len_i;
    logic              paddle_sel_i;
    logic              iambic_AB_i;
    logic              dit_i;
    logic              dah_i;
    logic              key_o;
    logic              aux_dit_o;
    logic              aux_dah_o;
    logic              elem_done_o;
    logic              elem_is_dah_o;
    logic              char_end_o;
    logic              word_end_o;
    logic              busy_o;

    modport master (
        output unit_len_i, paddle_sel_i, iambic_AB_i, dit_i, dah_i,
        input  key_o, aux_dit_o, aux_dah_o, elem_done_o, elem_is_dah_o,
               char_end_o, word_end_o, busy_o
    );

    modport slave (
        input  unit_len_i, paddle_sel_i, iambic_AB_i, dit_i, dah_i,
        output key_o, aux_dit_o, aux_dah_o, elem_done_o, elem_is_dah_o,
               char_end_o, word_end_o, busy_o
    );
endinterface

// File: rtl/iambic_element_sequencer.sv
// Paddle-to-key scheduler: sequences dit/dah elements, inter-element spaces and
// char/word gap events from iambic paddles or a straight key, timed in units.
module iambic_element_sequencer #(
    parameter int unsigned UNIT_W = 20
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    iambic_element_sequencer_if.slave     bus
);
    localparam int unsigned GAP_W   = 3;
    localparam int unsigned UNITS_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_DIT_ON, ST_DAH_ON, ST_SPACE, ST_GAP, ST_KEY_DOWN
    } state_e;

    state_e             state_q, state_d;
    logic [UNIT_W-1:0]  cnt_q, cnt_d;
    logic [UNITS_W-1:0] units_q, units_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               last_dah_q, last_dah_d;
    logic               squeeze_q, squeeze_d;
    logic               ab_q, ab_d;

    logic key_q, key_d, aux_dit_q, aux_dit_d, aux_dah_q, aux_dah_d;
    logic elem_done_q, elem_done_d, elem_is_dah_q, elem_is_dah_d;
    logic char_end_q, char_end_d, word_end_q, word_end_d, busy_q, busy_d;

    logic [UNIT_W-1:0] unit_load;
    logic tick, both, sq_b;
    logic elem_end, end_is_dah, char_hit, word_hit;
    logic start_dit, start_dah, start_key;

    // A programmed length of 0 behaves as 1 cycle per unit.
    assign unit_load = (bus.unit_len_i == '0) ? '0 : bus.unit_len_i - UNIT_W'(1);
    assign tick      = (cnt_q == '0);
    assign both      = bus.dit_i & bus.dah_i;
    assign sq_b      = ab_q & (squeeze_q | both);

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            units_q       <= '0;
            gap_q         <= '0;
            last_dah_q    <= 1'b0;
            squeeze_q     <= 1'b0;
            ab_q          <= 1'b0;
            key_q         <= 1'b0;
            aux_dit_q     <= 1'b0;
            aux_dah_q     <= 1'b0;
            elem_done_q   <= 1'b0;
            elem_is_dah_q <= 1'b0;
            char_end_q    <= 1'b0;
            word_end_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            units_q       <= units_d;
            gap_q         <= gap_d;
            last_dah_q    <= last_dah_d;
            squeeze_q     <= squeeze_d;
            ab_q          <= ab_d;
            key_q         <= key_d;
            aux_dit_q     <= aux_dit_d;
            aux_dah_q     <= aux_dah_d;
            elem_done_q   <= elem_done_d;
            elem_is_dah_q <= elem_is_dah_d;
            char_end_q    <= char_end_d;
            word_end_q    <= word_end_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state, unit timer and gap bookkeeping.
    always_comb begin
        state_d    = state_q;
        cnt_d      = tick ? unit_load : cnt_q - UNIT_W'(1);
        units_d    = units_q;
        gap_d      = gap_q;
        last_dah_d = last_dah_q;
        squeeze_d  = squeeze_q;
        ab_d       = ab_q;
        elem_end   = 1'b0;
        end_is_dah = 1'b0;
        char_hit   = 1'b0;
        word_hit   = 1'b0;
        start_dit  = 1'b0;
        start_dah  = 1'b0;
        start_key  = 1'b0;

        if ((state_q == ST_DIT_ON || state_q == ST_DAH_ON || state_q == ST_SPACE) && both)
            squeeze_d = 1'b1;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                ab_d = bus.iambic_AB_i;
                if (state_q == ST_GAP && tick) begin
                    gap_d    = (gap_q == '1) ? gap_q : gap_q + GAP_W'(1);
                    char_hit = (gap_q == GAP_W'(2));
                    word_hit = (gap_q == GAP_W'(6));
                end
                if (bus.paddle_sel_i) begin
                    start_dit = bus.dit_i;
                    start_dah = !bus.dit_i && bus.dah_i;
                end else begin
                    start_key = bus.dit_i;
                end
                if (word_hit && !start_dit && !start_dah && !start_key)
                    state_d = ST_IDLE;
            end
            ST_DIT_ON, ST_DAH_ON: begin
                if (tick) begin
                    if (units_q == '0) begin
                        elem_end   = 1'b1;
                        end_is_dah = (state_q == ST_DAH_ON);
                        last_dah_d = end_is_dah;
                        state_d    = ST_SPACE;
                    end else begin
                        units_d = units_q - UNITS_W'(1);
                    end
                end
            end
            ST_SPACE: begin
                if (tick) begin
                    // Mode B squeeze memory turns "none" or "same again" into alternation.
                    if (both || (!bus.dit_i && !bus.dah_i && sq_b)) begin
                        start_dit = last_dah_q;
                        start_dah = !last_dah_q;
                    end else if (bus.dit_i) begin
                        start_dit = !(sq_b && !last_dah_q);
                        start_dah = sq_b && !last_dah_q;
                    end else if (bus.dah_i) begin
                        start_dit = sq_b && last_dah_q;
                        start_dah = !(sq_b && last_dah_q);
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_W'(1);
                    end
                end
            end
            ST_KEY_DOWN: begin
                if (!bus.dit_i) begin
                    elem_end = 1'b1;
                    state_d  = ST_GAP;
                    gap_d    = '0;
                    cnt_d    = unit_load;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_dit || start_dah) begin
            state_d   = start_dah ? ST_DAH_ON : ST_DIT_ON;
            units_d   = start_dah ? UNITS_W'(2) : '0;
            cnt_d     = unit_load;
            squeeze_d = 1'b0;
        end else if (start_key) begin
            state_d = ST_KEY_DOWN;
        end
    end

    // Output decode from the next state and this cycle's events.
    always_comb begin
        key_d         = state_d inside {ST_DIT_ON, ST_DAH_ON, ST_KEY_DOWN};
        aux_dit_d     = (state_d == ST_DIT_ON);
        aux_dah_d     = (state_d == ST_DAH_ON);
        busy_d        = (state_d != ST_IDLE);
        elem_done_d   = elem_end;
        elem_is_dah_d = end_is_dah;
        char_end_d    = char_hit;
        word_end_d    = word_hit;
    end

    assign bus.key_o         = key_q;
    assign bus.aux_dit_o     = aux_dit_q;
    assign bus.aux_dah_o     = aux_dah_q;
    assign bus.elem_done_o   = elem_done_q;
    assign bus.elem_is_dah_o = elem_is_dah_q;
    assign bus.char_end_o    = char_end_q;
    assign bus.word_end_o    = word_end_q;
    assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_iambic_element_sequencer.sv
// Bench for iambic_element_sequencer: directed keying scenarios plus random
// paddle traffic, all outputs compared every cycle with a timing-level model.
module tb_iambic_element_sequencer;
    localparam int unsigned UNIT_W = 20;
    localparam int M_IDLE = 0, M_ON = 1, M_SPACE = 2, M_GAP = 3, M_KEY = 4;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    iambic_element_sequencer_if #(.UNIT_W(UNIT_W)) bus ();
    iambic_element_sequencer #(.UNIT_W(UNIT_W)) dut (.clk_i(clk_i), .rstn_i(rstn_i), .bus(bus));

    int n_vec = 0, n_err = 0, cyc = 0;
    logic [UNIT_W-1:0] cfg_len = 4;
    bit cfg_sel = 1'b1, cfg_ab = 1'b0;

    // Model: phase, cycles left in phase, key-up cycles since last fall.
    int m_st, m_left, m_up;
    bit m_dah, m_last_dah, m_sq, m_sel, m_ab;
    logic [7:0] exp_out;

    // Monitor: key-high run lengths, element kinds, event cycles.
    int runs[$], elems[$];
    int run_len, fall_cyc, char_cyc, word_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_out();
        return {bus.key_o, bus.aux_dit_o, bus.aux_dah_o, bus.elem_done_o,
                bus.elem_is_dah_o, bus.char_end_o, bus.word_end_o, bus.busy_o};
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_left = 0; m_up = 0;
        m_dah = 0; m_last_dah = 0; m_sq = 0; m_sel = 0; m_ab = 0;
        exp_out = '0;
    endtask

    task automatic model_step(input bit dit, input bit dah, input bit sel, input bit ab,
                              input logic [UNIT_W-1:0] len);
        int L;
        bit done, isdah, ch, wd, both, go_dit, go_dah, none, same;
        L = (len == 0) ? 1 : int'(len);
        done = 0; isdah = 0; ch = 0; wd = 0; go_dit = 0; go_dah = 0;
        both = dit & dah;
        if (m_st == M_IDLE || m_st == M_GAP) begin m_sel = sel; m_ab = ab; end
        case (m_st)
            M_IDLE, M_GAP: begin
                if (m_st == M_GAP) begin
                    m_up++;
                    ch = (m_up == 3 * L);
                    wd = (m_up == 7 * L);
                end
                if (m_sel) begin go_dit = dit; go_dah = !dit && dah; end
                else if (dit) m_st = M_KEY;
                if (wd && !go_dit && !go_dah && m_st != M_KEY) m_st = M_IDLE;
            end
            M_ON: begin
                m_sq |= both;
                m_left--;
                if (m_left == 0) begin
                    done = 1; isdah = m_dah; m_last_dah = m_dah;
                    m_st = M_SPACE; m_left = L; m_up = 0;
                end
            end
            M_SPACE: begin
                m_sq |= both;
                m_up++;
                m_left--;
                if (m_left == 0) begin
                    if (both) begin go_dit = m_last_dah; go_dah = !m_last_dah; end
                    else begin go_dit = dit; go_dah = dah; end
                    none = !dit && !dah;
                    same = (dit && !dah && !m_last_dah) || (dah && !dit && m_last_dah);
                    if (m_ab && m_sq && (none || same)) begin
                        go_dit = m_last_dah; go_dah = !m_last_dah;
                    end
                    if (!go_dit && !go_dah) m_st = M_GAP;
                end
            end
            M_KEY: if (!dit) begin done = 1; m_st = M_GAP; m_up = 0; end
            default: m_st = M_IDLE;
        endcase
        if (go_dit || go_dah) begin
            m_st = M_ON; m_dah = go_dah; m_left = go_dah ? 3 * L : L; m_sq = 0;
        end
        exp_out = {m_st == M_ON || m_st == M_KEY, m_st == M_ON && !m_dah,
                   m_st == M_ON && m_dah, done, isdah, ch, wd, m_st != M_IDLE};
    endtask

    task automatic clear_mon();
        runs.delete(); elems.delete();
        run_len = 0; fall_cyc = -1; char_cyc = -1; word_cyc = -1;
    endtask

    // One clock: compare previous edge's outputs, record them, drive the next inputs.
    task automatic cycle(input bit d, input bit a);
        @(negedge clk_i);
        check($sformatf("outs@%0d", cyc), dut_out(), exp_out);
        if (bus.key_o) run_len++;
        else if (run_len > 0) begin runs.push_back(run_len); run_len = 0; fall_cyc = cyc; end
        if (bus.elem_done_o) elems.push_back(int'(bus.elem_is_dah_o));
        if (bus.char_end_o) char_cyc = cyc;
        if (bus.word_end_o) word_cyc = cyc;
        bus.dit_i = d; bus.dah_i = a;
        bus.unit_len_i = cfg_len; bus.paddle_sel_i = cfg_sel; bus.iambic_AB_i = cfg_ab;
        model_step(d, a, cfg_sel, cfg_ab, cfg_len);
        cyc++;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && m_st != M_IDLE; i++) cycle(0, 0);
        cycle(0, 0);
        cycle(0, 0);
        check({tag, "_busy"}, bus.busy_o, 0);
    endtask

    initial begin
        bus.dit_i = 0; bus.dah_i = 0;
        bus.unit_len_i = cfg_len; bus.paddle_sel_i = cfg_sel; bus.iambic_AB_i = cfg_ab;
        model_reset();
        #12;
        check("reset_outs", dut_out(), 0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Mode A dit, unit 4.
        clear_mon();
        cycle(1, 0); cycle(1, 0);
        drain("dit");
        check("dit_runs", runs.size(), 1);
        if (runs.size() > 0) check("dit_on_len", runs[0], 4);
        check("dit_elems", elems.size(), 1);
        if (elems.size() > 0) check("dit_kind", elems[0], 0);
        check("dit_char_delay", char_cyc - fall_cyc, 12);
        check("dit_word_delay", word_cyc - fall_cyc, 28);

        // Dah held 20 cycles: two dahs.
        clear_mon();
        repeat (20) cycle(0, 1);
        drain("dah");
        check("dah_runs", runs.size(), 2);
        foreach (runs[i]) check($sformatf("dah_on_len%0d", i), runs[i], 12);
        check("dah_elems", elems.size(), 2);

        // Squeeze released during first dit: mode A then mode B.
        for (int b = 0; b < 2; b++) begin
            cfg_ab = b[0];
            clear_mon();
            repeat (3) cycle(1, 1);
            drain("sq");
            check($sformatf("sq%0d_elems", b), elems.size(), b + 1);
            if (b == 1 && runs.size() == 2) check("sqB_dah_len", runs[1], 12);
            if (b == 1 && elems.size() == 2) check("sqB_second", elems[1], 1);
        end

        // Both held, mode A: alternation.
        cfg_ab = 0;
        clear_mon();
        repeat (48) cycle(1, 1);
        drain("alt");
        check("alt_count_ge4", elems.size() >= 4, 1);
        for (int i = 0; i < 4 && i < elems.size(); i++)
            check($sformatf("alt_kind%0d", i), elems[i], i % 2);

        // Straight key, unit 3, dah toggling.
        cfg_sel = 0; cfg_len = 3;
        cycle(0, 0);
        clear_mon();
        for (int i = 0; i < 10; i++) cycle(1, i[0]);
        for (int i = 0; i < 30; i++) cycle(0, i[0]);
        drain("straight");
        check("straight_len", runs.size() > 0 ? runs[0] : -1, 10);
        check("straight_char", char_cyc - fall_cyc, 9);
        check("straight_word", word_cyc - fall_cyc, 21);
        check("straight_kind", elems.size() == 1 ? elems[0] : -1, 0);

        // Reset mid-dah drops key asynchronously.
        cfg_sel = 1; cfg_len = 4;
        cycle(0, 0);
        cycle(0, 1);
        repeat (5) cycle(0, 0);
        #2 rstn_i = 1'b0;
        #1;
        check("rst_async_key", bus.key_o, 0);
        check("rst_async_aux_dah", bus.aux_dah_o, 0);
        model_reset();
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        clear_mon();
        repeat (40) cycle(0, 0);
        check("post_rst_events", (char_cyc != -1) || (word_cyc != -1) || (elems.size() != 0), 0);

        // Unit length 0 behaves as 1.
        cfg_len = 0;
        cycle(0, 0);
        clear_mon();
        cycle(1, 0);
        drain("len0");
        check("len0_dit", runs.size() > 0 ? runs[0] : -1, 1);
        check("len0_char", char_cyc - fall_cyc, 3);

        // Random episodes; length changes only while idle.
        for (int ep = 0; ep < 24; ep++) begin
            drain($sformatf("ep%0d", ep));
            cfg_len = UNIT_W'($urandom_range(0, 5));
            cfg_sel = ($urandom_range(0, 3) != 0);
            cfg_ab  = $urandom_range(0, 1) != 0;
            for (int r = 0; r < 25; r++) begin
                int pat, n;
                pat = $urandom_range(0, 3);
                n   = $urandom_range(1, 10);
                if ($urandom_range(0, 15) == 0) cfg_ab = !cfg_ab;
                if ($urandom_range(0, 15) == 0) cfg_sel = !cfg_sel;
                repeat (n) cycle(pat[0], pat[1]);
            end
        end
        drain("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
